// File: rtl/half_adder_sync.sv
// Registered multi-lane half adder: per-lane sum/carry, carry summary and a
// saturating count of accepted operations, all driven straight from flops.
module half_adder_sync #(
    parameter  int WIDTH = 1,
    parameter  int CNT_W = 16,
    localparam int CC_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             any_carry,
    output logic [CC_W-1:0]  carry_count,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;
    logic [CC_W-1:0]  count_next;
    logic             accept;

    assign accept     = in_valid;
    assign sum_next   = ip1 ^ ip2;
    assign carry_next = ip1 & ip2;

    // Popcount of the carry vector about to be registered.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_next = count_next + CC_W'(carry_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            sum         <= '0;
            carry       <= '0;
            any_carry   <= 1'b0;
            carry_count <= '0;
            op_count    <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                sum         <= sum_next;
                carry       <= carry_next;
                any_carry   <= |carry_next;
                carry_count <= count_next;
                // Saturate rather than wrap so a long run never reads as idle.
                if (op_count != {CNT_W{1'b1}}) begin
                    op_count <= op_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_half_adder_sync.sv
// Bench for half_adder_sync: three instances (1 lane, 8 lanes, 3-bit counter)
// driven from one vector table, results checked through an expectation queue.
module tb_half_adder_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a8, b8;

    always #5 clk = ~clk;

    // 8-lane instance
    logic       ov8, any8;
    logic [7:0] sum8, car8;
    logic [3:0] cc8;
    logic [15:0] oc8;
    // 1-lane instance
    logic       ov1, any1, sum1, car1, cc1;
    logic [15:0] oc1;
    // 1-lane instance with 3-bit counter
    logic       ov3, any3, sum3, car3, cc3;
    logic [2:0] oc3;

    half_adder_sync #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ip1(a8), .ip2(b8),
        .out_valid(ov8), .sum(sum8), .carry(car8), .any_carry(any8),
        .carry_count(cc8), .op_count(oc8));

    half_adder_sync #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ip1(a8[0]), .ip2(b8[0]),
        .out_valid(ov1), .sum(sum1), .carry(car1), .any_carry(any1),
        .carry_count(cc1), .op_count(oc1));

    half_adder_sync #(.WIDTH(1), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ip1(a8[0]), .ip2(b8[0]),
        .out_valid(ov3), .sum(sum3), .carry(car3), .any_carry(any3),
        .carry_count(cc3), .op_count(oc3));

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] es;
        logic [7:0] ec;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic       ov;
        logic       any;
        int         cc;
        int         oc16;
        int         oc3;
    } exp_t;

    vec_t tbl[21];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    int m_oc16 = 0;
    int m_oc3  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("w8_sum",   longint'(sum8), longint'(e.s));
        chk("w8_carry", longint'(car8), longint'(e.c));
        chk("w8_valid", longint'(ov8),  longint'(e.ov));
        chk("w8_any",   longint'(any8), longint'(e.any));
        chk("w8_ccnt",  longint'(cc8),  longint'(e.cc));
        chk("w8_opcnt", longint'(oc8),  longint'(e.oc16));
        chk("w1_sum",   longint'(sum1), longint'(e.s[0]));
        chk("w1_carry", longint'(car1), longint'(e.c[0]));
        chk("w1_valid", longint'(ov1),  longint'(e.ov));
        chk("w1_any",   longint'(any1), longint'(e.c[0]));
        chk("w1_ccnt",  longint'(cc1),  longint'(e.c[0]));
        chk("w1_opcnt", longint'(oc1),  longint'(e.oc16));
        chk("c3_valid", longint'(ov3),  longint'(e.ov));
        chk("c3_opcnt", longint'(oc3),  longint'(e.oc3));
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        rst      = t.r;
        in_valid = t.v;
        a8       = t.a;
        b8       = t.b;
        if (t.r) begin
            m_oc16 = 0;
            m_oc3  = 0;
        end else if (t.v) begin
            if (m_oc16 < 65535) m_oc16++;
            if (m_oc3 < 7) m_oc3++;
        end
        e.s    = t.es;
        e.c    = t.ec;
        e.ov   = !t.r && t.v;
        e.any  = |t.ec;
        e.cc   = $countones(t.ec);
        e.oc16 = m_oc16;
        e.oc3  = m_oc3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a8 = '0; b8 = '0;
        tbl = '{
            // reset for two cycles
            '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00},
            '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00},
            // truth table 00, 01, 10, 11
            '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00},
            '{1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00},
            '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00},
            '{1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01},
            // hold with toggling operands
            '{1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 8'h01},
            '{1'b0, 1'b0, 8'h01, 8'hFF, 8'h00, 8'h01},
            '{1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01},
            // reset wins over a valid operation
            '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00},
            '{1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00},
            // multi-lane patterns
            '{1'b0, 1'b1, 8'hF0, 8'h3C, 8'hCC, 8'h30},
            '{1'b0, 1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00},
            '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF},
            // further operations drive the 3-bit counter into saturation
            '{1'b0, 1'b1, 8'h0F, 8'h01, 8'h0E, 8'h01},
            '{1'b0, 1'b1, 8'h80, 8'h80, 8'h00, 8'h80},
            '{1'b0, 1'b1, 8'h12, 8'h34, 8'h26, 8'h10},
            '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00},
            '{1'b0, 1'b1, 8'h55, 8'h55, 8'h00, 8'h55},
            '{1'b0, 1'b1, 8'hC3, 8'h81, 8'h42, 8'h81},
            '{1'b0, 1'b0, 8'h3C, 8'hC3, 8'h42, 8'h81}
        };
        for (int i = 0; i < 21; i++) begin
            apply(tbl[i]);
        end

        // Hand-written corner: back-to-back 11 then idle, checked directly.
        apply('{1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF});
        chk("sat_hold_c3", longint'(oc3), 64'd7);
        chk("ccnt_full", longint'(cc8), 64'd8);
        apply('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF});
        chk("idle_valid", longint'(ov8), 64'd0);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
